// File: rtl/id_ex_stage_reg.sv
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : ID/EX pipeline register of the 5-stage MIPS pipeline, with
//                the load-use interlock. A load in EX or in MA whose
//                destination is a source of the instruction in ID holds PC
//                and IF/ID (Stall) and sends a bubble into EX. A taken
//                branch/jump (Flush) kills the ID instruction and cancels
//                the stall.
//  Options     : `define ID_EX_PERF_CNT_EN adds the StallCnt / FlushCnt
//                event counters.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module id_ex_stage_reg #(
  parameter int unsigned DW     = 32,
  parameter logic [31:0] NOP_IR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  // instruction in ID
  input  logic [31:0]   IF_ID_IR,
  input  logic [DW-1:0] IF_ID_PC4,
  input  logic [DW-1:0] ID_A,
  input  logic [DW-1:0] ID_B,
  input  logic [DW-1:0] ID_Imm,
  input  logic          ID_RegWr,
  input  logic          ID_MemtoReg,
  input  logic          ID_MemWr,
  input  logic [3:0]    ID_ALUCtr,
  // instruction in MA (second load-use window)
  input  logic [31:0]   EX_MA_IR,
  input  logic          EX_MA_RegWr,
  input  logic          EX_MA_MemtoReg,
  // wrong-path kill from EX
  input  logic          Flush,
  // registered ID/EX contents
  output logic [31:0]   ID_EX_IR,
  output logic [DW-1:0] ID_EX_PC4,
  output logic [DW-1:0] ID_EX_A,
  output logic [DW-1:0] ID_EX_B,
  output logic [DW-1:0] ID_EX_Imm,
  output logic          ID_EX_RegWr,
  output logic          ID_EX_MemtoReg,
  output logic          ID_EX_MemWr,
  output logic [3:0]    ID_EX_ALUCtr,
  output logic          ID_EX_Valid,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]   StallCnt,
  output logic [31:0]   FlushCnt,
`endif
  output logic          Stall
);

  // Opcodes whose rt field is read as a source operand.
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  // True when the instruction with this opcode reads register rt.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == c_OP_RTYPE) || (op == c_OP_BEQ) ||
           (op == c_OP_BNE)   || (op == c_OP_SW);
  endfunction

  // True when a producer that is a load (RegWr & MemtoReg) writes a
  // non-zero register that the consumer reads. $0 is hard-wired, so a
  // dependency on it never needs to wait.
  function automatic logic load_hit(
    input logic [4:0] dst,
    input logic       reg_wr,
    input logic       mem_to_reg,
    input logic [4:0] src_rs,
    input logic [4:0] src_rt,
    input logic       rt_is_src
  );
    return reg_wr && mem_to_reg && (dst != 5'd0) &&
           ((dst == src_rs) || (rt_is_src && (dst == src_rt)));
  endfunction

  // Source fields of the instruction in ID.
  logic [5:0] w_id_op;
  logic [4:0] w_id_rs;
  logic [4:0] w_id_rt;
  logic       w_id_uses_rt;

  assign w_id_op      = IF_ID_IR[31:26];
  assign w_id_rs      = IF_ID_IR[25:21];
  assign w_id_rt      = IF_ID_IR[20:16];
  assign w_id_uses_rt = uses_rt(w_id_op);

  // Load destinations are the rt field of the load.
  logic [4:0] w_ex_dst;
  logic [4:0] w_ma_dst;

  assign w_ex_dst = ID_EX_IR[20:16];
  assign w_ma_dst = EX_MA_IR[20:16];

  // Only the destination field of the MA instruction matters here.
  logic unused_ex_ma_bits;
  assign unused_ex_ma_bits = ^{EX_MA_IR[31:21], EX_MA_IR[15:0]};

  // Hazard windows: the load is one stage ahead (EX) or two (MA). Loads are
  // only forwardable from MA/WB, so both windows block the consumer.
  // EX carries a valid bit; MA bubbles are recognised by RegWr=0.
  logic w_haz_ex;
  logic w_haz_ma;
  logic w_hazard;

  assign w_haz_ex = ID_EX_Valid &&
                    load_hit(w_ex_dst, ID_EX_RegWr, ID_EX_MemtoReg,
                             w_id_rs, w_id_rt, w_id_uses_rt);
  assign w_haz_ma = load_hit(w_ma_dst, EX_MA_RegWr, EX_MA_MemtoReg,
                             w_id_rs, w_id_rt, w_id_uses_rt);
  assign w_hazard = w_haz_ex || w_haz_ma;

  // A flushed ID instruction is wrong-path, so there is nothing to hold.
  assign Stall = w_hazard && !Flush;

  // Pipeline register: reset and flush/stall load a bubble, otherwise
  // the decoded ID instruction moves into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_IR       <= NOP_IR;
      ID_EX_PC4      <= '0;
      ID_EX_A        <= '0;
      ID_EX_B        <= '0;
      ID_EX_Imm      <= '0;
      ID_EX_RegWr    <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_MemWr    <= 1'b0;
      ID_EX_ALUCtr   <= 4'h0;
      ID_EX_Valid    <= 1'b0;
    end else if (Flush || Stall) begin
      ID_EX_IR       <= NOP_IR;
      ID_EX_PC4      <= '0;
      ID_EX_A        <= '0;
      ID_EX_B        <= '0;
      ID_EX_Imm      <= '0;
      ID_EX_RegWr    <= 1'b0;
      ID_EX_MemtoReg <= 1'b0;
      ID_EX_MemWr    <= 1'b0;
      ID_EX_ALUCtr   <= 4'h0;
      ID_EX_Valid    <= 1'b0;
    end else begin
      ID_EX_IR       <= IF_ID_IR;
      ID_EX_PC4      <= IF_ID_PC4;
      ID_EX_A        <= ID_A;
      ID_EX_B        <= ID_B;
      ID_EX_Imm      <= ID_Imm;
      ID_EX_RegWr    <= ID_RegWr;
      ID_EX_MemtoReg <= ID_MemtoReg;
      ID_EX_MemWr    <= ID_MemWr;
      ID_EX_ALUCtr   <= ID_ALUCtr;
      ID_EX_Valid    <= 1'b1;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Event counters: one count per edge with Stall / Flush, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= 32'h0;
      FlushCnt <= 32'h0;
    end else begin
      StallCnt <= StallCnt + {31'h0, Stall};
      FlushCnt <= FlushCnt + {31'h0, Flush};
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none

module tb_id_ex_stage_reg;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   IF_ID_IR;
  logic [DW-1:0] IF_ID_PC4, ID_A, ID_B, ID_Imm;
  logic          ID_RegWr, ID_MemtoReg, ID_MemWr;
  logic [3:0]    ID_ALUCtr;
  logic [31:0]   EX_MA_IR;
  logic          EX_MA_RegWr, EX_MA_MemtoReg;
  logic          Flush;
  logic [31:0]   ID_EX_IR;
  logic [DW-1:0] ID_EX_PC4, ID_EX_A, ID_EX_B, ID_EX_Imm;
  logic          ID_EX_RegWr, ID_EX_MemtoReg, ID_EX_MemWr;
  logic [3:0]    ID_EX_ALUCtr;
  logic          ID_EX_Valid;
  logic          Stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]   StallCnt, FlushCnt;
`endif

  id_ex_stage_reg #(.DW(DW), .NOP_IR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_IR(IF_ID_IR), .IF_ID_PC4(IF_ID_PC4),
    .ID_A(ID_A), .ID_B(ID_B), .ID_Imm(ID_Imm),
    .ID_RegWr(ID_RegWr), .ID_MemtoReg(ID_MemtoReg), .ID_MemWr(ID_MemWr),
    .ID_ALUCtr(ID_ALUCtr),
    .EX_MA_IR(EX_MA_IR), .EX_MA_RegWr(EX_MA_RegWr), .EX_MA_MemtoReg(EX_MA_MemtoReg),
    .Flush(Flush),
    .ID_EX_IR(ID_EX_IR), .ID_EX_PC4(ID_EX_PC4),
    .ID_EX_A(ID_EX_A), .ID_EX_B(ID_EX_B), .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_RegWr(ID_EX_RegWr), .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_MemWr(ID_EX_MemWr),
    .ID_EX_ALUCtr(ID_EX_ALUCtr), .ID_EX_Valid(ID_EX_Valid),
`ifdef ID_EX_PERF_CNT_EN
    .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
    .Stall(Stall)
  );

  // Reference model: contents of EX and MA stages as whole instructions.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4, a, b, imm;
    logic        regwr, memtoreg, memwr;
    logic [3:0]  alu;
    logic        valid;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t      m_ex, m_ma, cur_id, dut_ex;
  logic [31:0] m_scnt, m_fcnt;
  int          checks = 0;
  int          errors = 0;

  assign dut_ex = {ID_EX_IR, ID_EX_PC4, ID_EX_A, ID_EX_B, ID_EX_Imm,
                   ID_EX_RegWr, ID_EX_MemtoReg, ID_EX_MemWr, ID_EX_ALUCtr, ID_EX_Valid};

  // Build an instruction with controls a decoder would produce for its opcode.
  function automatic stage_t make_inst(input logic [31:0] ir);
    stage_t s;
    s.ir = ir; s.pc4 = $urandom; s.a = $urandom; s.b = $urandom; s.imm = $urandom;
    s.alu = 4'($urandom);
    s.regwr = (ir[31:26] == 6'd0) || (ir[31:26] == 6'd35) || (ir[31:26] == 6'd8);
    s.memtoreg = (ir[31:26] == 6'd35);
    s.memwr = (ir[31:26] == 6'd43);
    s.valid = 1'b1;
    return s;
  endfunction

  // Does a load (producer) write a register the consumer reads?
  function automatic logic load_feeds(input logic [31:0] p_ir, input logic wr, input logic m2r,
                                      input logic [31:0] c_ir);
    logic [4:0] d;
    logic [5:0] op;
    logic reads_rt;
    d = p_ir[20:16];
    op = c_ir[31:26];
    reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
    return wr && m2r && (d != 5'd0) &&
           ((d == c_ir[25:21]) || (reads_rt && d == c_ir[20:16]));
  endfunction

  function automatic logic exp_stall();
    return !Flush && ((m_ex.valid && load_feeds(m_ex.ir, m_ex.regwr, m_ex.memtoreg, IF_ID_IR)) ||
                      load_feeds(EX_MA_IR, EX_MA_RegWr, EX_MA_MemtoReg, IF_ID_IR));
  endfunction

  task automatic drive_id(input stage_t s);
    cur_id = s;
    IF_ID_IR = s.ir; IF_ID_PC4 = s.pc4; ID_A = s.a; ID_B = s.b; ID_Imm = s.imm;
    ID_RegWr = s.regwr; ID_MemtoReg = s.memtoreg; ID_MemWr = s.memwr; ID_ALUCtr = s.alu;
  endtask

  // One clock edge: advance the model alongside the DUT, then move the
  // former EX instruction into the (bench-side) MA stage.
  task automatic tick();
    stage_t nx;
    logic   s;
    s = exp_stall();
    if (rst || Flush || s) nx = BUBBLE;
    else begin nx = cur_id; nx.valid = 1'b1; end
    @(posedge clk);
    if (rst) begin m_scnt = 0; m_fcnt = 0; end
    else begin m_scnt = m_scnt + 32'(s); m_fcnt = m_fcnt + 32'(Flush); end
    #1;
    m_ma = rst ? BUBBLE : m_ex;
    m_ex = nx;
    EX_MA_IR = m_ma.ir; EX_MA_RegWr = m_ma.regwr; EX_MA_MemtoReg = m_ma.memtoreg;
  endtask

  // Present an instruction in ID until it is captured; report stall cycles.
  task automatic present(input logic [31:0] ir, output int stalls);
    stalls = 0;
    Flush = 1'b0;
    drive_id(make_inst(ir));
    for (int k = 0; k < 8; k++) begin
      #1;
      if (Stall !== 1'b1) break;
      stalls++;
      tick();
    end
    if (stalls >= 8) stalls = 99;
    tick();
  endtask

  task automatic drain();
    int s;
    present(32'h0, s);
    present(32'h0, s);
  endtask

  task automatic test_reset();
    rst = 1'b1; Flush = 1'b0;
    EX_MA_IR = $urandom; EX_MA_RegWr = 1'b0; EX_MA_MemtoReg = 1'($urandom);
    drive_id(make_inst($urandom));
    tick();
    drive_id(make_inst($urandom));
    tick();
    #1;
    checks++; if (ID_EX_IR !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want 0", ID_EX_IR); end
    checks++; if (ID_EX_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ID_EX_Valid); end
    checks++; if ({ID_EX_RegWr, ID_EX_MemtoReg, ID_EX_MemWr, ID_EX_ALUCtr} !== 7'h0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0", {ID_EX_RegWr, ID_EX_MemtoReg, ID_EX_MemWr, ID_EX_ALUCtr}); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall); end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    drain();
    present(32'h8D28_0000, s0);
    present(32'h010B_5020, s1);
    checks++; if (s0 != 0) begin errors++; $display("FAIL b2b_lw_stall: got %0d want 0", s0); end
    checks++; if (s1 != 2) begin errors++; $display("FAIL b2b_add_stalls: got %0d want 2", s1); end
    checks++; if (ID_EX_IR !== 32'h010B_5020 || ID_EX_Valid !== 1'b1)
      begin errors++; $display("FAIL b2b_capture: got ir=%h v=%b want ir=010b5020 v=1", ID_EX_IR, ID_EX_Valid); end
    checks++; if (dut_ex !== m_ex) begin errors++; $display("FAIL b2b_regs: got %h want %h", dut_ex, m_ex); end
  endtask

  task automatic test_gap_one();
    int s0, s1, s2;
    drain();
    present(32'h8D28_0000, s0);
    present(32'h0043_0825, s1);
    present(32'hAC88_0004, s2);
    checks++; if (s1 != 0) begin errors++; $display("FAIL gap_or_stalls: got %0d want 0", s1); end
    checks++; if (s2 != 1) begin errors++; $display("FAIL gap_sw_stalls: got %0d want 1", s2); end
  endtask

  task automatic test_operand_cases();
    int s0, s1, s2;
    drain(); present(32'h8D20_0000, s0); present(32'h0000_5020, s1);
    checks++; if (s1 != 0) begin errors++; $display("FAIL zero_reg_stalls: got %0d want 0", s1); end
    drain(); present(32'h8D28_0000, s0); present(32'h2109_0001, s1);
    checks++; if (s1 != 2) begin errors++; $display("FAIL addi_rs_stalls: got %0d want 2", s1); end
    drain(); present(32'h8D28_0000, s0); present(32'h2028_0001, s1);
    checks++; if (s1 != 0) begin errors++; $display("FAIL addi_rt_dst_stalls: got %0d want 0", s1); end
    drain(); present(32'h8D28_0000, s0); present(32'h0108_0820, s1);
    checks++; if (s1 != 2) begin errors++; $display("FAIL rs_rt_same_stalls: got %0d want 2", s1); end
    drain(); present(32'h8C28_0000, s0); present(32'h8C49_0000, s1); present(32'h0109_0820, s2);
    checks++; if (s1 != 0 || s2 != 2)
      begin errors++; $display("FAIL two_loads_stalls: got %0d/%0d want 0/2", s1, s2); end
  endtask

  task automatic test_flush_stall();
    int s0;
    drain();
    present(32'h8D28_0000, s0);
    drive_id(make_inst(32'h010B_5020));
    #1;
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: got %b want 1", Stall); end
    Flush = 1'b1;
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", Stall); end
    tick();
    Flush = 1'b0;
    checks++; if (ID_EX_Valid !== 1'b0 || ID_EX_IR !== 32'h0)
      begin errors++; $display("FAIL flush_bubble: got ir=%h v=%b want ir=0 v=0", ID_EX_IR, ID_EX_Valid); end
    drive_id(make_inst(32'h0043_0825));
    #1;
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL flush_next_stall: got %b want 0", Stall); end
    tick();
    checks++; if (ID_EX_IR !== 32'h0043_0825 || ID_EX_Valid !== 1'b1)
      begin errors++; $display("FAIL flush_next_capture: got ir=%h v=%b want ir=00430825 v=1", ID_EX_IR, ID_EX_Valid); end
  endtask

  task automatic test_reset_mid_stall();
    int s0;
    drain();
    present(32'h8D28_0000, s0);
    drive_id(make_inst(32'h010B_5020));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (ID_EX_Valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", ID_EX_Valid); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", Stall); end
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8};
    logic       held = 1'b0;
    logic       e;
    logic [31:0] ir;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        ir = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
        drive_id(make_inst(ir));
      end
      Flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      #1;
      e = exp_stall();
      checks++; if (Stall !== e) begin errors++; $display("FAIL rand_stall[%0d]: got %b want %b", n, Stall, e); end
      held = e && !rst;
      tick();
      checks++; if (dut_ex !== m_ex) begin errors++; $display("FAIL rand_regs[%0d]: got %h want %h", n, dut_ex, m_ex); end
    end
    rst = 1'b0; Flush = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
    checks++; if (StallCnt !== m_scnt) begin errors++; $display("FAIL rand_stallcnt: got %0d want %0d", StallCnt, m_scnt); end
    checks++; if (FlushCnt !== m_fcnt) begin errors++; $display("FAIL rand_flushcnt: got %0d want %0d", FlushCnt, m_fcnt); end
`endif
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    int s0, s1;
    rst = 1'b1; Flush = 1'b0; drive_id(make_inst(32'h0));
    tick();
    rst = 1'b0;
    checks++; if (StallCnt !== 32'h0 || FlushCnt !== 32'h0)
      begin errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", StallCnt, FlushCnt); end
    present(32'h8D28_0000, s0);
    present(32'h010B_5020, s1);
    drive_id(make_inst(32'h0));
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    checks++; if (StallCnt !== 32'd2) begin errors++; $display("FAIL perf_stallcnt: got %0d want 2", StallCnt); end
    checks++; if (FlushCnt !== 32'd1) begin errors++; $display("FAIL perf_flushcnt: got %0d want 1", FlushCnt); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    m_ex = BUBBLE; m_ma = BUBBLE; m_scnt = 0; m_fcnt = 0;
    rst = 1'b1; Flush = 1'b0;
    EX_MA_IR = 32'h0; EX_MA_RegWr = 1'b0; EX_MA_MemtoReg = 1'b0;
    drive_id(BUBBLE);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_gap_one();
    test_operand_cases();
    test_flush_stall();
    test_reset_mid_stall();
`ifdef ID_EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
